io_port_bank: RTL

//   Parametrised multi-channel I/O port unit for the microcontroller datapath; replaces the single fixed 8-bit input port.

---
 rtl/io_port_bank_pkg.sv | 15 +
 rtl/io_port_bank_in_chan.sv | 55 +++++
 rtl/io_port_bank.sv | 123 ++++++++++++
 3 files changed

// File: rtl/io_port_bank_pkg.sv
// io_port_bank_pkg: default geometry of the I/O port bank and the status-register address helper.
// Status word layout (LSB first): in_ready[N_IN], ovr[N_IN], irq_mask[N_IN] (IO_IRQ_EN only), zero pad.
package io_port_bank_pkg;

   localparam int unsigned IO_DATA_W_DEF = 8;
   localparam int unsigned IO_N_IN_DEF   = 4;
   localparam int unsigned IO_N_OUT_DEF  = 4;
   localparam int unsigned IO_ADDR_W_DEF = 3;

   // The status register always sits at the top of the I/O address space.
   function automatic int unsigned status_addr(input int unsigned addr_w);
      return (32'd1 << addr_w) - 32'd1;
   endfunction

endpackage

// File: rtl/io_port_bank_in_chan.sv
// io_in_chan: one input channel. It synchronises the asynchronous producer strobe, captures on its
// rising edge, and keeps the ready and sticky-overrun flags.
module io_in_chan
   import io_port_bank_pkg::*;
#(
   parameter int unsigned DATA_W = IO_DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_strobe,
   input  logic              i_rd_clr,
   input  logic              i_ovr_clr,
   output logic [DATA_W-1:0] o_hold,
   output logic              o_ready,
   output logic              o_ovr
);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_sync3;
   logic [DATA_W-1:0] r_hold;
   logic              r_ready;
   logic              r_ovr;
   logic              w_capture;

   assign w_capture = r_sync2 & ~r_sync3;

   // A capture in the same cycle as a read of this channel keeps ready set and is not an overrun.
   // An overrun coinciding with a status read stays set so it is not lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_hold  <= '0;
         r_ready <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_sync1 <= i_strobe;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         if (w_capture) begin
            r_hold <= i_data;
         end
         r_ready <= w_capture | (r_ready & ~i_rd_clr);
         r_ovr   <= (r_ovr & ~i_ovr_clr) | (w_capture & r_ready & ~i_rd_clr);
      end
   end

   assign o_hold  = r_hold;
   assign o_ready = r_ready;
   assign o_ovr   = r_ovr;

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: multi-channel I/O port unit with address decode, output registers, read mux and status.
// Optional feature macro IO_IRQ_EN adds an irq_mask register (written at the status address) and the irq output.
module io_port_bank
   import io_port_bank_pkg::*;
#(
   parameter int unsigned DATA_W = IO_DATA_W_DEF,
   parameter int unsigned N_IN   = IO_N_IN_DEF,
   parameter int unsigned N_OUT  = IO_N_OUT_DEF,
   parameter int unsigned ADDR_W = IO_ADDR_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       io_addr,
   input  logic                    io_we,
   input  logic [DATA_W-1:0]       io_wdata,
   input  logic                    io_re,
   output logic [DATA_W-1:0]       io_rdata,
   input  logic [N_IN*DATA_W-1:0]  in_port,
   input  logic [N_IN-1:0]         in_strobe,
   output logic [N_IN-1:0]         in_ready,
   output logic [N_OUT*DATA_W-1:0] out_port,
   output logic [N_OUT-1:0]        out_valid
`ifdef IO_IRQ_EN
   ,
   output logic                    irq
`endif
);

   localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(ADDR_W));

   logic [DATA_W-1:0]       w_hold [N_IN];
   logic [N_IN-1:0]         w_ready;
   logic [N_IN-1:0]         w_ovr;
   logic [N_IN-1:0]         w_rd_clr;
   logic                    w_ovr_clr;
   logic [DATA_W-1:0]       w_status;
   logic [DATA_W-1:0]       w_rd_sel;
   logic [DATA_W-1:0]       r_rdata;
   logic [N_OUT*DATA_W-1:0] r_out;
   logic [N_OUT-1:0]        r_valid;

   assign w_ovr_clr = io_re & (io_addr == STATUS_ADDR);

   for (genvar g = 0; g < N_IN; g++) begin : g_in
      assign w_rd_clr[g] = io_re & (io_addr == ADDR_W'(g));

      io_in_chan #(
         .DATA_W (DATA_W)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .i_data    (in_port[g*DATA_W +: DATA_W]),
         .i_strobe  (in_strobe[g]),
         .i_rd_clr  (w_rd_clr[g]),
         .i_ovr_clr (w_ovr_clr),
         .o_hold    (w_hold[g]),
         .o_ready   (w_ready[g]),
         .o_ovr     (w_ovr[g])
      );
   end

`ifdef IO_IRQ_EN
   logic [N_IN-1:0] r_mask;
   logic            r_irq;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mask <= '0;
         r_irq  <= 1'b0;
      end else begin
         if (io_we && (io_addr == STATUS_ADDR)) begin
            r_mask <= io_wdata[N_IN-1:0];
         end
         r_irq <= (|(w_ready & r_mask)) | (|w_ovr);
      end
   end

   assign irq      = r_irq;
   // Fields beyond DATA_W are dropped when 3*N_IN exceeds the bus width.
   assign w_status = DATA_W'({r_mask, w_ovr, w_ready});
`else
   assign w_status = DATA_W'({w_ovr, w_ready});
`endif

   always_comb begin
      w_rd_sel = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (io_addr == ADDR_W'(k)) begin
            w_rd_sel = w_hold[k];
         end
      end
      if (io_addr == STATUS_ADDR) begin
         w_rd_sel = w_status;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata <= '0;
         r_out   <= '0;
         r_valid <= '0;
      end else begin
         r_valid <= '0;
         if (io_we) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
               if (io_addr == ADDR_W'(k)) begin
                  r_out[k*DATA_W +: DATA_W] <= io_wdata;
                  r_valid[k]                <= 1'b1;
               end
            end
         end
         if (io_re) begin
            r_rdata <= w_rd_sel;
         end
      end
   end

   assign io_rdata  = r_rdata;
   assign in_ready  = w_ready;
   assign out_port  = r_out;
   assign out_valid = r_valid;

endmodule
